song_sequencer: RTL

// Playback controller downstream of the song ROM (memory_cell). Walks note index 0..SONG_LEN-1 of the selected song,

---
 rtl/song_pkg.sv | 43 ++++
 rtl/song_sequencer_note_timer.sv | 37 +++
 rtl/song_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/song_pkg.sv
// Package: song_pkg
// Shared constants, state encoding and song-select codes for the song playback
// controller (song_sequencer) and its note timer.
//   SONG_LEN   : default notes per song
//   GAP_CYCLES : default silent cycles between notes
//   NOTE_W     : note code width
//   DUR_W      : duration / counter width
//   LOC_W      : ROM address width
package song_pkg;

  localparam int SONG_LEN   = 26;
  localparam int GAP_CYCLES = 5_000_000;
  localparam int NOTE_W     = 4;
  localparam int DUR_W      = 26;
  localparam int LOC_W      = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_PLAY  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Song-select codes; SONG_NONE maps to a ROM region that returns zeros.
  localparam logic [1:0] SONG_NONE = 2'd0;
  localparam logic [1:0] SONG_1    = 2'd1;
  localparam logic [1:0] SONG_2    = 2'd2;
  localparam logic [1:0] SONG_3    = 2'd3;

  // Playback is in progress in every state except IDLE and DONE.
  function automatic logic is_busy(input state_t st);
    logic b;
    case (st)
      ST_IDLE: b = 1'b0;
      ST_DONE: b = 1'b0;
      default: b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/song_sequencer_note_timer.sv
// Module: note_timer
// Loadable down-counter shared by the note (PLAY) and articulation gap (GAP)
// phases. It saturates at zero and flags zero combinationally.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : load load_value (has priority over en)
//   en         : decrement by one when non-zero
//   load_value : value to load
//   zero       : counter equals zero
module note_timer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Counter register: load, decrement toward zero, or hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/song_sequencer.sv
// Module: song_sequencer
// Playback controller behind the song ROM. Walks note index 0..SONG_LEN-1 of
// the latched song, reads {note, duration} over the 1-cycle-latency ROM port,
// sounds each note for its duration, then inserts a silent gap so repeated
// notes re-attack. A zero duration terminates the song early.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : level; begins playback of songnum from IDLE/DONE
//   stop          : level; abort to IDLE from any state (highest priority)
//   pause         : level; freezes PLAY/GAP timing and mutes the tone
//   songnum       : song select, latched at start
//   rom_isread    : ROM read enable
//   rom_location  : ROM address (current note index)
//   rom_songnum   : latched song select to ROM
//   rom_note      : ROM note data (valid the cycle after a read)
//   rom_dur       : ROM duration data (same timing)
//   note_out      : current note code to tone generator
//   note_on       : tone enable
//   busy          : playback in progress
//   done          : one-cycle pulse on entry to DONE
//   cur_index     : index of the note being fetched/played
module song_sequencer #(
  parameter int SONG_LEN   = 26,
  parameter int GAP_CYCLES = 5_000_000,
  parameter int NOTE_W     = 4,
  parameter int DUR_W      = 26,
  parameter int LOC_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [1:0]        songnum,
  output logic              rom_isread,
  output logic [LOC_W-1:0]  rom_location,
  output logic [1:0]        rom_songnum,
  input  logic [NOTE_W-1:0] rom_note,
  input  logic [DUR_W-1:0]  rom_dur,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_on,
  output logic              busy,
  output logic              done,
  output logic [LOC_W-1:0]  cur_index
);

  import song_pkg::*;

  // Elaboration-time configuration checks.
  if ((GAP_CYCLES < 1) ||
      (longint'(GAP_CYCLES) - longint'(1) >= (longint'(1) << DUR_W))) begin : g_gap_cfg_err
    $error("song_sequencer: GAP_CYCLES must be >= 1 and GAP_CYCLES-1 must fit DUR_W");
  end
  if ((longint'(1) << LOC_W) < longint'(SONG_LEN)) begin : g_loc_cfg_err
    $error("song_sequencer: 2**LOC_W must be >= SONG_LEN");
  end

  localparam logic [DUR_W-1:0] GAP_LOAD = DUR_W'(GAP_CYCLES - 1);
  localparam logic [LOC_W-1:0] LAST_IDX = LOC_W'(SONG_LEN - 1);

  state_t              state_r;
  state_t              state_nx_s;
  logic [LOC_W-1:0]    index_r;
  logic [1:0]          songnum_r;
  logic [NOTE_W-1:0]   note_r;
  logic                isread_r;
  logic                play_r;
  logic                busy_r;
  logic                done_r;

  logic                begin_s;      // accept start: latch song, rewind index
  logic                advance_s;    // gap finished, move to next index
  logic                capture_s;    // take ROM note into note_out
  logic                tmr_load_s;
  logic                tmr_en_s;
  logic [DUR_W-1:0]    tmr_load_val_s;
  logic                tmr_zero_s;

  note_timer #(.W(DUR_W)) u_note_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load_s),
    .en         (tmr_en_s),
    .load_value (tmr_load_val_s),
    .zero       (tmr_zero_s)
  );

  // Next-state decode and timer control for the playback FSM.
  always_comb begin
    state_nx_s     = state_r;
    begin_s        = 1'b0;
    advance_s      = 1'b0;
    capture_s      = 1'b0;
    tmr_load_s     = 1'b0;
    tmr_en_s       = 1'b0;
    tmr_load_val_s = '0;
    if (stop) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_nx_s = ST_FETCH;
            begin_s    = 1'b1;
          end else begin
            state_nx_s = state_r;
          end
        end
        ST_FETCH: begin
          state_nx_s = ST_LATCH;
        end
        ST_LATCH: begin
          // Zero duration is the song terminator (and all of song 0).
          if (rom_dur == '0) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s     = ST_PLAY;
            capture_s      = 1'b1;
            tmr_load_s     = 1'b1;
            tmr_load_val_s = rom_dur - DUR_W'(1);
          end
        end
        ST_PLAY: begin
          if (pause) begin
            state_nx_s = ST_PLAY;
          end else if (tmr_zero_s) begin
            state_nx_s     = ST_GAP;
            tmr_load_s     = 1'b1;
            tmr_load_val_s = GAP_LOAD;
          end else begin
            tmr_en_s = 1'b1;
          end
        end
        ST_GAP: begin
          if (pause) begin
            state_nx_s = ST_GAP;
          end else if (tmr_zero_s) begin
            if (index_r == LAST_IDX) begin
              state_nx_s = ST_DONE;
            end else begin
              state_nx_s = ST_FETCH;
              advance_s  = 1'b1;
            end
          end else begin
            tmr_en_s = 1'b1;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state, index/song latches and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      index_r   <= '0;
      songnum_r <= SONG_NONE;
      note_r    <= '0;
      isread_r  <= 1'b0;
      play_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_nx_s;

      if (begin_s) begin
        songnum_r <= songnum;
        index_r   <= '0;
      end else if (advance_s) begin
        index_r <= index_r + LOC_W'(1);
      end else begin
        index_r <= index_r;
      end

      if (state_nx_s == ST_IDLE) begin
        note_r <= '0;
      end else if (capture_s) begin
        note_r <= rom_note;
      end else begin
        note_r <= note_r;
      end

      isread_r <= (state_nx_s == ST_FETCH) || (state_nx_s == ST_LATCH);
      play_r   <= (state_nx_s == ST_PLAY);
      busy_r   <= is_busy(state_nx_s);
      done_r   <= (state_nx_s == ST_DONE) && (state_r != ST_DONE);
    end
  end

  assign rom_isread   = isread_r;
  assign rom_location = index_r;
  assign cur_index    = index_r;
  assign rom_songnum  = songnum_r;
  assign note_out     = note_r;
  // Pause mutes within the same cycle so paused cycles never sound.
  assign note_on      = play_r & ~pause;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule
